// File: rtl/magia_eoc_collector_if.sv
// Bundle of run-control, tile-event and status signals between the tile array/host and
// the EOC collector. The master side drives controls and tile events; the slave is the collector.
interface magia_eoc_collector_if #(
  parameter int unsigned N_TILES   = 4,
  parameter int unsigned EXIT_W    = 16,
  parameter int unsigned TIMEOUT_W = 32
);
  logic                        start_i;
  logic                        clear_i;
  logic [TIMEOUT_W-1:0]        timeout_cycles_i;
  logic [N_TILES-1:0]          tile_eoc_i;
  logic [N_TILES*EXIT_W-1:0]   tile_exit_code_i;
  logic                        busy_o;
  logic                        eoc_o;
  logic                        timeout_o;
  logic [N_TILES-1:0]          done_mask_o;
  logic [N_TILES*EXIT_W-1:0]   exit_code_o;
  logic                        fail_o;
  logic                        dup_err_o;

  modport master (
    output start_i, clear_i, timeout_cycles_i, tile_eoc_i, tile_exit_code_i,
    input  busy_o, eoc_o, timeout_o, done_mask_o, exit_code_o, fail_o, dup_err_o
  );

  modport slave (
    input  start_i, clear_i, timeout_cycles_i, tile_eoc_i, tile_exit_code_i,
    output busy_o, eoc_o, timeout_o, done_mask_o, exit_code_o, fail_o, dup_err_o
  );
endinterface

// File: rtl/magia_eoc_collector.sv
// Collects per-tile EOC edges and exit codes into one aggregated done/fail status,
// with a run watchdog that ends the run in TIMEOUT if not all tiles report in time.
module magia_eoc_collector #(
  parameter int unsigned N_TILES   = 4,
  parameter int unsigned EXIT_W    = 16,
  parameter int unsigned TIMEOUT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  magia_eoc_collector_if.slave  bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;
  localparam logic [1:0] StTimeout = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [N_TILES-1:0]        eoc_q, eoc_d;
  logic [N_TILES-1:0]        done_mask_q, done_mask_d;
  logic [N_TILES*EXIT_W-1:0] exit_code_q, exit_code_d;
  logic                      dup_err_q, dup_err_d;
  logic [TIMEOUT_W-1:0]      cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]      limit_q, limit_d;

  logic [N_TILES-1:0]        eoc_edge;
  logic [N_TILES-1:0]        done_next;
  logic                      is_eoc;

  always_comb begin
    state_d     = state_q;
    done_mask_d = done_mask_q;
    exit_code_d = exit_code_q;
    dup_err_d   = dup_err_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    // Edge history tracks the inputs in every state so a level held across start is not an event.
    eoc_d       = bus.tile_eoc_i;
    eoc_edge    = bus.tile_eoc_i & ~eoc_q;
    done_next   = done_mask_q | eoc_edge;

    if (bus.clear_i) begin
      state_d     = StIdle;
      done_mask_d = '0;
      exit_code_d = '0;
      dup_err_d   = 1'b0;
      cnt_d       = '0;
      limit_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            state_d     = StRun;
            cnt_d       = '0;
            limit_d     = bus.timeout_cycles_i;
            done_mask_d = '0;
            exit_code_d = '0;
            dup_err_d   = 1'b0;
          end
        end
        StRun: begin
          done_mask_d = done_next;
          for (int unsigned t = 0; t < N_TILES; t++) begin
            if (eoc_edge[t] && !done_mask_q[t]) begin
              exit_code_d[t*EXIT_W +: EXIT_W] = bus.tile_exit_code_i[t*EXIT_W +: EXIT_W];
            end
          end
          if (|(eoc_edge & done_mask_q)) dup_err_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + TIMEOUT_W'(1);
          // Completion is checked first so a last capture on the expiry cycle still yields DONE.
          if (&done_next) begin
            state_d = StDone;
          end else if ((limit_q != '0) && (cnt_q == limit_q - TIMEOUT_W'(1))) begin
            state_d = StTimeout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      eoc_q       <= '0;
      done_mask_q <= '0;
      exit_code_q <= '0;
      dup_err_q   <= 1'b0;
      cnt_q       <= '0;
      limit_q     <= '0;
    end else begin
      state_q     <= state_d;
      eoc_q       <= eoc_d;
      done_mask_q <= done_mask_d;
      exit_code_q <= exit_code_d;
      dup_err_q   <= dup_err_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
    end
  end

  assign is_eoc          = (state_q == StDone) || (state_q == StTimeout);
  assign bus.busy_o      = (state_q == StRun);
  assign bus.eoc_o       = is_eoc;
  assign bus.timeout_o   = (state_q == StTimeout);
  assign bus.done_mask_o = done_mask_q;
  assign bus.exit_code_o = exit_code_q;
  assign bus.dup_err_o   = dup_err_q;
  assign bus.fail_o      = is_eoc && ((state_q == StTimeout) || (|exit_code_q) || dup_err_q);

endmodule

// File: tb/tb_magia_eoc_collector.sv
// Directed bench for the EOC collector: a per-tile behavioural model is compared against the DUT
// on every falling edge, and directed scenarios add literal expectations.
module tb_magia_eoc_collector;
  localparam int unsigned NT = 4;
  localparam int unsigned EW = 16;
  localparam int unsigned TW = 32;

  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MDone = 2;
  localparam int MTout = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  magia_eoc_collector_if #(.N_TILES(NT), .EXIT_W(EW), .TIMEOUT_W(TW)) bus ();

  magia_eoc_collector #(.N_TILES(NT), .EXIT_W(EW), .TIMEOUT_W(TW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- model ----------------
  int          m_phase;
  bit          m_got [NT];
  logic [EW-1:0] m_code [NT];
  bit          m_dup;
  longint      m_elapsed;
  longint      m_limit;
  logic [NT-1:0] m_prev;

  task automatic model_reset();
    m_phase = MIdle;
    for (int t = 0; t < NT; t++) begin
      m_got[t]  = 1'b0;
      m_code[t] = '0;
    end
    m_dup     = 1'b0;
    m_elapsed = 0;
    m_limit   = 0;
    m_prev    = '0;
  endtask

  task automatic model_step();
    int n_done;
    if (bus.clear_i) begin
      m_phase = MIdle;
      for (int t = 0; t < NT; t++) begin
        m_got[t]  = 1'b0;
        m_code[t] = '0;
      end
      m_dup = 1'b0;
    end else if (m_phase == MIdle) begin
      if (bus.start_i) begin
        m_phase   = MRun;
        m_elapsed = 0;
        m_limit   = longint'(bus.timeout_cycles_i);
      end
    end else if (m_phase == MRun) begin
      for (int t = 0; t < NT; t++) begin
        if (bus.tile_eoc_i[t] && !m_prev[t]) begin
          if (m_got[t]) m_dup = 1'b1;
          else begin
            m_got[t]  = 1'b1;
            m_code[t] = bus.tile_exit_code_i[t*EW +: EW];
          end
        end
      end
      m_elapsed++;
      n_done = 0;
      for (int t = 0; t < NT; t++) if (m_got[t]) n_done++;
      if (n_done == NT) m_phase = MDone;
      else if (m_limit != 0 && m_elapsed == m_limit) m_phase = MTout;
    end
    m_prev = bus.tile_eoc_i;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      logic [NT-1:0]    e_mask;
      logic [NT*EW-1:0] e_code;
      logic             e_eoc, e_tout, e_fail, any_code;
      @(negedge clk_i);
      any_code = 1'b0;
      for (int t = 0; t < NT; t++) begin
        e_mask[t]            = m_got[t];
        e_code[t*EW +: EW]   = m_code[t];
        if (m_code[t] != '0) any_code = 1'b1;
      end
      e_eoc  = (m_phase == MDone) || (m_phase == MTout);
      e_tout = (m_phase == MTout);
      e_fail = e_eoc && (e_tout || any_code || m_dup);
      chk("model_flags",
          128'({bus.busy_o, bus.eoc_o, bus.timeout_o, bus.fail_o, bus.dup_err_o}),
          128'({m_phase == MRun, e_eoc, e_tout, e_fail, m_dup}));
      chk("model_done_mask", 128'(bus.done_mask_o), 128'(e_mask));
      chk("model_exit_code", 128'(bus.exit_code_o), 128'(e_code));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
  endtask

  task automatic clear_all();
    bus.clear_i    = 1'b1;
    bus.tile_eoc_i = '0;
    tick(1);
    bus.clear_i = 1'b0;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bus.start_i          = 1'b0;
    bus.clear_i          = 1'b0;
    bus.timeout_cycles_i = '0;
    bus.tile_eoc_i       = '0;
    bus.tile_exit_code_i = '0;
    tick(2);
    chk("reset_flags", 128'({bus.busy_o, bus.eoc_o, bus.timeout_o, bus.fail_o, bus.dup_err_o}),
        128'(0));
    chk("reset_mask", 128'(bus.done_mask_o), 128'(0));
    rst_i = 1'b0;
    tick(1);

    // 1: tiles edge 5,9,9,20 cycles after start, all codes 0; eoc in the following cycle
    pulse_start();
    tick(4);
    bus.tile_eoc_i = 4'b0001;
    tick(1);
    chk("t1_mask_a", 128'(bus.done_mask_o), 128'(4'b0001));
    tick(3);
    bus.tile_eoc_i = 4'b0111;
    tick(1);
    chk("t1_mask_b", 128'(bus.done_mask_o), 128'(4'b0111));
    tick(10);
    chk("t1_eoc_early", 128'(bus.eoc_o), 128'(0));
    bus.tile_eoc_i = 4'b1111;
    tick(1);
    chk("t1_mask_c", 128'(bus.done_mask_o), 128'(4'b1111));
    chk("t1_eoc", 128'({bus.eoc_o, bus.fail_o}), 128'(2'b10));
    clear_all();

    // 2: tile 2 exits 0x00AB
    bus.tile_exit_code_i = 64'h0000_00AB_0000_0000;
    pulse_start();
    tick(2);
    bus.tile_eoc_i = 4'b1111;
    tick(1);
    chk("t2_codes", 128'(bus.exit_code_o), 128'(64'h0000_00AB_0000_0000));
    chk("t2_fail", 128'({bus.eoc_o, bus.fail_o}), 128'(2'b11));
    clear_all();
    bus.tile_exit_code_i = '0;

    // 3: watchdog 50, only tiles 0,1 finish; a stray start mid-run is ignored
    bus.timeout_cycles_i = 50;
    pulse_start();
    bus.timeout_cycles_i = '0;
    tick(9);
    bus.tile_eoc_i = 4'b0011;
    tick(21);
    bus.start_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    tick(18);
    chk("t3_before", 128'({bus.busy_o, bus.eoc_o}), 128'(2'b10));
    tick(1);
    chk("t3_timeout", 128'({bus.eoc_o, bus.timeout_o, bus.fail_o}), 128'(3'b111));
    chk("t3_mask", 128'(bus.done_mask_o), 128'(4'b0011));
    clear_all();

    // 4: tile 1 edges with code 5, then again with code 7
    pulse_start();
    tick(2);
    bus.tile_exit_code_i = 64'h0000_0000_0005_0000;
    bus.tile_eoc_i = 4'b0010;
    tick(1);
    bus.tile_eoc_i = 4'b0000;
    tick(2);
    bus.tile_exit_code_i = 64'h0000_0000_0007_0000;
    bus.tile_eoc_i = 4'b0010;
    tick(1);
    chk("t4_code", 128'(bus.exit_code_o), 128'(64'h0000_0000_0005_0000));
    chk("t4_dup", 128'({bus.busy_o, bus.dup_err_o, bus.fail_o}), 128'(3'b110));
    bus.tile_eoc_i = 4'b1111;
    tick(1);
    chk("t4_end", 128'({bus.eoc_o, bus.fail_o, bus.dup_err_o}), 128'(3'b111));
    clear_all();
    bus.tile_exit_code_i = '0;

    // 5: last tile edges on the watchdog expiry cycle -> DONE
    bus.timeout_cycles_i = 20;
    pulse_start();
    bus.timeout_cycles_i = '0;
    tick(4);
    bus.tile_eoc_i = 4'b0111;
    tick(15);
    bus.tile_eoc_i = 4'b1111;
    tick(1);
    chk("t5_done", 128'({bus.eoc_o, bus.timeout_o, bus.fail_o}), 128'(3'b100));
    chk("t5_mask", 128'(bus.done_mask_o), 128'(4'b1111));
    clear_all();

    // 6: pre-start levels, clear+start, reset mid-run
    bus.tile_eoc_i = 4'b1111;
    tick(2);
    pulse_start();
    tick(3);
    chk("t6_held", 128'({bus.busy_o, bus.done_mask_o}), 128'({1'b1, 4'b0000}));
    bus.tile_eoc_i = 4'b1110;
    tick(1);
    bus.tile_eoc_i = 4'b1111;
    tick(1);
    chk("t6_reedge", 128'(bus.done_mask_o), 128'(4'b0001));
    bus.clear_i = 1'b1;
    bus.start_i = 1'b1;
    tick(1);
    bus.clear_i = 1'b0;
    bus.start_i = 1'b0;
    chk("t6_clear", 128'({bus.busy_o, bus.eoc_o, bus.done_mask_o}), 128'(0));
    pulse_start();
    bus.tile_eoc_i = '0;
    tick(1);
    bus.tile_exit_code_i = 64'h0000_1234_0000_0000;
    bus.tile_eoc_i = 4'b0100;
    tick(1);
    chk("t6_capture", 128'(bus.exit_code_o), 128'(64'h0000_1234_0000_0000));
    rst_i = 1'b1;
    #1;
    chk("t6_rst", 128'({bus.busy_o, bus.done_mask_o, bus.exit_code_o}), 128'(0));
    tick(1);
    rst_i = 1'b0;
    tick(2);
    chk("t6_after_rst", 128'({bus.busy_o, bus.eoc_o, bus.done_mask_o}), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
